// File: rtl/halut_encoder.sv
// halut_encoder
//   Pipelined HALUT encoder. For each accepted FP16 activation vector it walks a
//   depth-TreeDepth binary decision tree using the per-codebook thresholds of the
//   current codebook, emitting one (c_addr_o, k_addr_o, valid_o) triple per input,
//   TreeDepth cycles after acceptance. The codebook counter advances per accepted input.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   waddr_i/wdata_i/we_i  threshold write {c, node}; node K-1 is dropped
//   enc_valid_i        input vector valid (no backpressure)
//   a_input_i          one FP16 activation per tree level, level l at [l*DW +: DW]
//   clear_i            synchronous clear of codebook counter and pipeline valids
//   c_addr_o/k_addr_o  codebook and selected prototype of the emitted result
//   valid_o, last_o    result valid; last_o flags codebook C-1
module halut_encoder #(
  parameter int unsigned K              = 16,
  parameter int unsigned C              = 32,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned TreeDepth      = $clog2(K),
  parameter int unsigned CAddrWidth     = $clog2(C),
  parameter int unsigned TotalAddrWidth = $clog2(C * K)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [TotalAddrWidth-1:0]           waddr_i,
  input  logic [DataTypeWidth-1:0]            wdata_i,
  input  logic                                we_i,
  input  logic                                enc_valid_i,
  input  logic [TreeDepth*DataTypeWidth-1:0]  a_input_i,
  input  logic                                clear_i,
  output logic [CAddrWidth-1:0]               c_addr_o,
  output logic [TreeDepth-1:0]                k_addr_o,
  output logic                                valid_o,
  output logic                                last_o
);

  localparam int unsigned DW = DataTypeWidth;
  localparam int unsigned TD = TreeDepth;
  localparam int unsigned CW = CAddrWidth;

  // Monotonic FP16 key: -0 folds onto +0, negatives are inverted, positives get
  // the sign bit set, so an unsigned key compare orders the finite values.
  function automatic logic [DW-1:0] f_key(input logic [DW-1:0] x);
    logic [DW-1:0] v;
    v = (x == {1'b1, {(DW-1){1'b0}}}) ? '0 : x;
    return v[DW-1] ? ~v : (v | {1'b1, {(DW-1){1'b0}}});
  endfunction

  // ---------------------------------------------------------------------------
  // Threshold register file
  // ---------------------------------------------------------------------------
  logic [DW-1:0] r_thr [C][K-1];
  logic [CW-1:0] w_wc;
  logic [TD-1:0] w_wnode;

  assign w_wc    = waddr_i[TotalAddrWidth-1 -: CW];
  assign w_wnode = waddr_i[TD-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_thr <= '{default: '0};
    end else if (we_i && (w_wnode != TD'(K - 1))) begin
      r_thr[w_wc][w_wnode] <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Codebook counter
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_c_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_c_cnt <= '0;
    end else if (clear_i) begin
      r_c_cnt <= '0;
    end else if (enc_valid_i) begin
      r_c_cnt <= (r_c_cnt == CW'(C - 1)) ? '0 : r_c_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Tree pipeline
  //   Stage l decides level l combinationally from its source (the input port
  //   for l = 0, otherwise the register of stage l-1) and registers the result.
  //   The register of the last stage is the output register, giving a latency
  //   of exactly TD cycles. Activations already consumed are not carried on.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < TD; l++) begin : g_stage
    logic                 w_in_vld;
    logic [CW-1:0]        w_in_c;
    logic [(TD-l)*DW-1:0] w_in_a;
    logic [TD-1:0]        w_node;
    logic [l:0]           w_next_p;
    logic [DW-1:0]        w_thr;
    logic                 w_bit;

    logic                 r_vld;
    logic [CW-1:0]        r_c;
    logic [l:0]           r_p;

    if (l == 0) begin : g_src
      assign w_in_vld = enc_valid_i;
      assign w_in_c   = r_c_cnt;
      assign w_in_a   = a_input_i;
      assign w_node   = '0;
      assign w_next_p = w_bit;
    end else begin : g_src
      // Heap order: level l starts at node 2^l - 1, offset by the prefix so far.
      assign w_in_vld = g_stage[l-1].r_vld;
      assign w_in_c   = g_stage[l-1].r_c;
      assign w_in_a   = g_stage[l-1].g_act.r_a;
      assign w_node   = TD'((2 ** l) - 1) + TD'(g_stage[l-1].r_p);
      assign w_next_p = {g_stage[l-1].r_p, w_bit};
    end

    assign w_thr = r_thr[w_in_c][w_node];
    // Strict compare: equality goes left.
    assign w_bit = (f_key(w_in_a[DW-1:0]) > f_key(w_thr));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld <= 1'b0;
        r_c   <= '0;
        r_p   <= '0;
      end else if (clear_i) begin
        r_vld <= 1'b0;
      end else begin
        r_vld <= w_in_vld;
        r_c   <= w_in_c;
        r_p   <= w_next_p;
      end
    end

    if (l < TD - 1) begin : g_act
      logic [(TD-1-l)*DW-1:0] r_a;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_a <= '0;
        end else if (!clear_i) begin
          r_a <= w_in_a[(TD-l)*DW-1:DW];
        end
      end
    end
  end

  logic r_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b0;
    end else if (clear_i) begin
      r_last <= 1'b0;
    end else begin
      r_last <= g_stage[TD-1].w_in_vld && (g_stage[TD-1].w_in_c == CW'(C - 1));
    end
  end

  assign valid_o  = g_stage[TD-1].r_vld;
  assign c_addr_o = g_stage[TD-1].r_c;
  assign k_addr_o = g_stage[TD-1].r_p;
  assign last_o   = r_last;

endmodule

// File: tb/tb_halut_encoder.sv
// tb_halut_encoder
//   Directed bench for halut_encoder (K=16, C=32, FP16, depth 4). Inputs change
//   1 time unit after the rising edge; outputs are sampled at the same point.
module tb_halut_encoder;

  logic        clk_i;
  logic        rst_ni;
  logic [8:0]  waddr_i;
  logic [15:0] wdata_i;
  logic        we_i;
  logic        enc_valid_i;
  logic [63:0] a_input_i;
  logic        clear_i;
  logic [4:0]  c_addr_o;
  logic [3:0]  k_addr_o;
  logic        valid_o;
  logic        last_o;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [63:0] AllPos  = 64'h3C00_3C00_3C00_3C00;
  localparam logic [63:0] AllNeg  = 64'hBC00_BC00_BC00_BC00;
  localparam logic [63:0] Alt     = 64'hBC00_3C00_BC00_3C00;
  localparam logic [63:0] Heap    = 64'h0000_0000_BC00_4200;
  localparam logic [63:0] AllZero = 64'h0000_0000_0000_0000;
  localparam logic [63:0] AllNegZ = 64'h8000_8000_8000_8000;

  halut_encoder #(
    .K  (16),
    .C  (32),
    .DataTypeWidth (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .enc_valid_i (enc_valid_i),
    .a_input_i   (a_input_i),
    .clear_i     (clear_i),
    .c_addr_o    (c_addr_o),
    .k_addr_o    (k_addr_o),
    .valid_o     (valid_o),
    .last_o      (last_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [63:0] a);
    a_input_i   = a;
    enc_valid_i = 1'b1;
    tick();
    enc_valid_i = 1'b0;
  endtask

  // Called right after send(): result is due after the third following edge,
  // and the cycle after that must be empty again.
  task automatic expect_result(input string tag, input logic [3:0] k, input logic [4:0] c);
    tick(); tick(); tick();
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_k"},     32'(k_addr_o), 32'(k));
    chk({tag, "_c"},     32'(c_addr_o), 32'(c));
    chk({tag, "_last"},  32'(last_o), (c == 5'd31) ? 32'd1 : 32'd0);
    tick();
    chk({tag, "_gap"},   32'(valid_o), 32'd0);
  endtask

  task automatic wr(input logic [4:0] c, input logic [3:0] node, input logic [15:0] d);
    waddr_i = {c, node};
    wdata_i = d;
    we_i    = 1'b1;
    tick();
    we_i    = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    logic bub [7];
    bub = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_ni      = 1'b0;
    waddr_i     = '0;
    wdata_i     = '0;
    we_i        = 1'b0;
    enc_valid_i = 1'b0;
    a_input_i   = '0;
    clear_i     = 1'b0;

    #2;
    chk("rst_valid", 32'(valid_o),  32'd0);
    chk("rst_last",  32'(last_o),   32'd0);
    chk("rst_k",     32'(k_addr_o), 32'd0);
    chk("rst_c",     32'(c_addr_o), 32'd0);
    #10 rst_ni = 1'b1;

    // Tree traversal with all-zero thresholds
    send(AllPos); expect_result("tree_pos", 4'd15, 5'd0);
    send(AllNeg); expect_result("tree_neg", 4'd0,  5'd1);
    send(Alt);    expect_result("tree_alt", 4'd10, 5'd2);

    // Heap addressing on codebook 3: 3.0 > 2.0 -> 1, node 2: -1.0 > -2.0 -> 1
    wr(5'd3, 4'd0, 16'h4000);
    wr(5'd3, 4'd2, 16'hC000);
    wr(5'd3, 4'd15, 16'h4000);  // node K-1: must be dropped
    send(Heap);   expect_result("heap", 4'd12, 5'd3);

    // Equality and signed zero go left
    send(AllZero); expect_result("eq_pzero", 4'd0, 5'd4);
    send(AllNegZ); expect_result("eq_nzero", 4'd0, 5'd5);

    // Wrap and last: 33 back-to-back inputs from a cleared counter
    do_clear();
    a_input_i = AllNeg;
    for (int i = 0; i < 37; i++) begin
      enc_valid_i = (i < 33);
      tick();
      if (i >= 3 && i < 36) begin
        chk("wrap_valid", 32'(valid_o),  32'd1);
        chk("wrap_c",     32'(c_addr_o), 32'((i - 3) % 32));
        chk("wrap_last",  32'(last_o),   ((i - 3) == 31) ? 32'd1 : 32'd0);
        chk("wrap_k",     32'(k_addr_o), 32'd0);
      end else begin
        chk("wrap_idle_valid", 32'(valid_o), 32'd0);
        chk("wrap_idle_last",  32'(last_o),  32'd0);
      end
    end
    enc_valid_i = 1'b0;

    // Bubbles propagate
    do_clear();
    for (int i = 0; i < 7; i++) begin
      enc_valid_i = bub[i];
      tick();
      if (i >= 3) begin
        chk("bub_valid", 32'(valid_o), 32'(bub[i-3]));
        if (bub[i-3]) chk("bub_c", 32'(c_addr_o), (i == 3) ? 32'd0 : 32'd1);
      end else begin
        chk("bub_idle", 32'(valid_o), 32'd0);
      end
    end
    enc_valid_i = 1'b0;

    // Clear with three results in flight; the input during clear is discarded
    a_input_i = AllPos;
    enc_valid_i = 1'b1;
    tick(); tick(); tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    enc_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_valid", 32'(valid_o), 32'd0);
      chk("clr_last",  32'(last_o),  32'd0);
      tick();
    end
    send(AllNeg); expect_result("clr_next", 4'd0, 5'd0);

    // Write/read collision on stage 0 of codebook 0: old threshold (0) used
    do_clear();
    a_input_i   = AllPos;
    enc_valid_i = 1'b1;
    waddr_i     = {5'd0, 4'd0};
    wdata_i     = 16'h4000;
    we_i        = 1'b1;
    tick();
    enc_valid_i = 1'b0;
    we_i        = 1'b0;
    expect_result("coll_old", 4'd15, 5'd0);
    // New value (2.0) now in force and retained across clear: path 0,1,1,1
    do_clear();
    send(AllPos); expect_result("coll_new", 4'd7, 5'd0);

    // Asynchronous reset mid-stream
    a_input_i   = AllPos;
    enc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_valid", 32'(valid_o),  32'd1);
    chk("pre_rst_c",     32'(c_addr_o), 32'd1);
    chk("pre_rst_k",     32'(k_addr_o), 32'd15);
    rst_ni      = 1'b0;
    enc_valid_i = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_o),  32'd0);
    chk("mrst_k",     32'(k_addr_o), 32'd0);
    chk("mrst_c",     32'(c_addr_o), 32'd0);
    chk("mrst_last",  32'(last_o),   32'd0);
    #2 rst_ni = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid_o), 32'd0);
    // Thresholds cleared by reset: codebook 0 root is back to 0
    send(AllPos); expect_result("post_rst_thr", 4'd15, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/halut_encoder.md
# halut_encoder

Pipelined HALUT encoder that produces the LUT read addresses consumed by the decoder units. For each codebook `c`, it walks a depth-`TreeDepth` binary decision tree over FP16 activations, using per-codebook thresholds held in a local register file. Each accepted input vector yields one `(c_addr_o, k_addr_o, valid_o)` triple. These outputs drive the decoder's `c_addr_i`, `k_addr_i` and `decoder_i` directly. Throughput is one codebook per cycle.

## Interface
- `K`, 16: prototypes per codebook; power of two.
- `C`, 32: codebooks.
- `DataTypeWidth`, 16: FP16 operand width.
- `TreeDepth`, `$clog2(K)`: tree levels and pipeline stages.
- `CAddrWidth`, `$clog2(C)`: codebook index width.
- `TotalAddrWidth`, `$clog2(C*K)`: threshold write address width.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `waddr_i`, in, `TotalAddrWidth`: threshold write address `{c, node}`; `node` ranges 0..K-2; `node` K-1 is ignored.
- `wdata_i`, in, `DataTypeWidth`: FP16 threshold.
- `we_i`, in, 1: threshold write enable.
- `enc_valid_i`, in, 1: input vector valid.
- `a_input_i`, in, `TreeDepth*DataTypeWidth`: FP16 activation per level; level `l` is at `[l*DataTypeWidth +: DataTypeWidth]`.
- `clear_i`, in, 1: synchronous clear of the codebook counter and pipeline.
- `c_addr_o`, out, `CAddrWidth`: codebook of the emitted result.
- `k_addr_o`, out, `TreeDepth`: selected prototype index.
- `valid_o`, out, 1: result valid; connects to the decoder's `decoder_i`.
- `last_o`, out, 1: asserted with `valid_o` when `c_addr_o == C-1`.

## Operation
- **Threshold storage**: flop array of `C*(K-1)` entries.
  - A write with `we_i` updates entry `{c, node}` at the clock edge.
  - Writes with `node == K-1` are dropped.
  - The array has `TreeDepth` combinational read ports, one per stage.
  - Reset value of every entry is 0x0000.
- **Codebook counter `c_cnt`**:
  - Increments on every accepted input (`enc_valid_i` high at the edge).
  - Wraps from C-1 to 0.
  - Reset and `clear_i` set it to 0.
- **Stage `l`** (0..TreeDepth-1) holds a valid bit, `c`, an `l`-bit prefix `p`, and the remaining activations.
  - `node = 2^l - 1 + p`.
  - Threshold `t = thr[c][node]`.
  - `bit = (a_l > t)`; strict compare, so equality goes left (0).
  - New prefix is `{p, bit}`, with the MSB being the root decision.
- **FP16 compare**:
  - Build a monotonic key: `key = sign ? ~x : x | 16'h8000`.
  - Map -0 (0x8000) to +0 before keying.
  - Compare keys unsigned.
  - NaN and Inf behaviour is unspecified; the bench must not drive them.
- **Output**: the final stage register drives `k_addr_o = p`, plus `c_addr_o`, `valid_o` and `last_o`.
- **Ordering**: results emerge in acceptance order. Bubbles (`enc_valid_i` low) propagate as `valid_o` low.
- **Write/read collision**: a threshold write in the same cycle as a stage read returns the old value. The new value is used from the next cycle.
- **`clear_i`**:
  - Zeroes `c_cnt` and all stage valid bits at the edge.
  - Any input presented in the same cycle is discarded.
  - Thresholds are retained.
- **Reset**: all outputs are 0, all stage valid bits are 0, `c_cnt` is 0 and all thresholds are 0.

## Timing
- Latency is exactly `TreeDepth` cycles. An input sampled at edge E appears on the outputs after edge E+TreeDepth-1, i.e. in the `TreeDepth`-th cycle after the input cycle.
- There is no backpressure; the block accepts one input per cycle indefinitely.
- `valid_o` is a single-cycle pulse per result. Back-to-back inputs give continuous `valid_o`.
- `c_addr_o` increments by 1 mod C across consecutive valid results. `last_o` is high only in the cycle carrying codebook C-1.
- `last_o` and `valid_o` are never high without `valid_o`; after `clear_i` or reset both are low until a new input reaches the last stage.
- Asynchronous reset mid-stream drops all in-flight results immediately.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Test plan
- **Tree traversal**:
  - Setup: all thresholds 0x0000.
  - `a_input` all 0x3C00 (1.0) → `k_addr_o` = 15, `c_addr_o` = 0, after 4 cycles.
  - `a_input` all 0xBC00 (-1.0) → `k_addr_o` = 0.
  - Levels {1.0, -1.0, 1.0, -1.0} → `k_addr_o` = 4'b1010 = 10.
- **Heap addressing**:
  - Setup: for c=3, program `thr[3][0]` = 0x4000 (2.0) and `thr[3][2]` = 0xC000 (-2.0).
  - Inputs: levels {3.0, -1.0, 0, 0}, presented so they land on c=3.
  - Expected: `k_addr_o[3:2]` = 2'b11.
- **Equality and signed zero**: with threshold 0x0000, level inputs of 0x8000 and 0x0000 both go left → `k_addr_o` = 0.
- **Wrap and last**:
  - Stimulus: 33 back-to-back inputs.
  - Expected: `c_addr_o` = 0..31 then 0; `last_o` high only with `c_addr_o` = 31; `valid_o` continuously high for 33 cycles.
- **Bubbles and clear**:
  - Stimulus: valid, idle, valid → `valid_o` shows the same gap, with `c_addr_o` = 0 then 1.
  - Stimulus: `clear_i` with 3 results in flight → no further `valid_o`; the next input emits `c_addr_o` = 0.
- **Write collision and reset**:
  - Stimulus: write a threshold in the same cycle its stage reads it.
  - Expected: the old value is used; the following input uses the new value.
  - Stimulus: assert `rst_ni` low mid-stream.
  - Expected: all outputs 0 immediately; thresholds read back as 0 afterwards.
